alu_issue_controller: RTL and testbench

Multi-cycle issue controller that drives the 32-bit ALU from the control side. It accepts one instruction word per valid/ready handshake, reads source operands from the register file, and encodes the ALU control word and operands. It then captures the ALU result and writes it back to the register file. It is the initiator for the ALU, which it treats as a purely combinational responder, and it sits between instruction fetch and the register file.

---
 rtl/alu_issue_controller.sv | 150 +++++++++++++++
 tb/tb_alu_issue_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_controller.sv
// Multi-cycle issue controller for a combinational 32-bit ALU.
// Flow: IDLE -> DECODE -> EXEC -> WB. Illegal instructions leave DECODE
// straight back to IDLE and raise a one-cycle ILLEGAL pulse.
module alu_issue_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      INS_VALID,
  output logic                      INS_READY,
  input  logic [31:0]               INS,
  output logic [REG_ADDR_WIDTH-1:0] RF_RA1,
  output logic [REG_ADDR_WIDTH-1:0] RF_RA2,
  input  logic [DATA_WIDTH-1:0]     RF_RD1,
  input  logic [DATA_WIDTH-1:0]     RF_RD2,
  output logic [DATA_WIDTH-1:0]     ALU_A,
  output logic [DATA_WIDTH-1:0]     ALU_B,
  output logic [3:0]                ALUC,
  input  logic [DATA_WIDTH-1:0]     ALU_R,
  output logic                      RF_WE,
  output logic [REG_ADDR_WIDTH-1:0] RF_WA,
  output logic [DATA_WIDTH-1:0]     RF_WD,
  output logic                      ILLEGAL,
  output logic                      BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  localparam logic [3:0] C_ADD = 4'b0000, C_SUB = 4'b0100, C_AND = 4'b0001,
                         C_OR  = 4'b0101, C_XOR = 4'b0010, C_LUI = 4'b0110,
                         C_SLL = 4'b0011, C_SRL = 4'b0111, C_SRA = 4'b1111;

  state_t                    r_state;
  logic [31:0]               r_ir;
  logic [REG_ADDR_WIDTH-1:0] r_ra1, r_ra2, r_dest, r_wa;
  logic [DATA_WIDTH-1:0]     r_alu_a, r_alu_b, r_wd;
  logic [3:0]                r_aluc;
  logic                      r_ill;

  logic                      w_legal;
  logic [3:0]                w_aluc;
  logic [DATA_WIDTH-1:0]     w_a, w_b;
  logic [REG_ADDR_WIDTH-1:0] w_dest;

  logic [5:0]                w_op, w_fn;
  logic [DATA_WIDTH-1:0]     w_sext, w_zext, w_shamt;

  assign w_op    = r_ir[31:26];
  assign w_fn    = r_ir[5:0];
  assign w_sext  = {{(DATA_WIDTH-16){r_ir[15]}}, r_ir[15:0]};
  assign w_zext  = {{(DATA_WIDTH-16){1'b0}}, r_ir[15:0]};
  assign w_shamt = {{(DATA_WIDTH-5){1'b0}}, r_ir[10:6]};

  // Decode the latched instruction into ALU control, operands and destination
  always_comb begin
    w_legal = 1'b0;
    w_aluc  = C_ADD;
    w_a     = RF_RD1;
    w_b     = RF_RD2;
    w_dest  = REG_ADDR_WIDTH'(r_ir[15:11]);
    if (w_op == 6'b000000) begin
      w_legal = 1'b1;
      case (w_fn)
        6'b100000: w_aluc = C_ADD;
        6'b100010: w_aluc = C_SUB;
        6'b100100: w_aluc = C_AND;
        6'b100101: w_aluc = C_OR;
        6'b100110: w_aluc = C_XOR;
        6'b000000: begin w_aluc = C_SLL; w_a = w_shamt; end
        6'b000010: begin w_aluc = C_SRL; w_a = w_shamt; end
        6'b000011: begin w_aluc = C_SRA; w_a = w_shamt; end
        default:   w_legal = 1'b0;
      endcase
    end else begin
      w_legal = 1'b1;
      w_dest  = REG_ADDR_WIDTH'(r_ir[20:16]);
      w_b     = w_zext;
      case (w_op)
        6'b001000: begin w_aluc = C_ADD; w_b = w_sext; end
        6'b001100: w_aluc = C_AND;
        6'b001101: w_aluc = C_OR;
        6'b001110: w_aluc = C_XOR;
        6'b001111: begin w_aluc = C_LUI; w_a = '0; end
        default:   w_legal = 1'b0;
      endcase
    end
  end

  // Issue FSM with registered operand, control and write-back outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_ra1   <= '0;
      r_ra2   <= '0;
      r_dest  <= '0;
      r_wa    <= '0;
      r_wd    <= '0;
      r_alu_a <= '0;
      r_alu_b <= '0;
      r_aluc  <= C_ADD;
      r_ill   <= 1'b0;
    end else begin
      r_ill <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (INS_VALID) begin
            r_ir    <= INS;
            r_ra1   <= REG_ADDR_WIDTH'(INS[25:21]);
            r_ra2   <= REG_ADDR_WIDTH'(INS[20:16]);
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_alu_a <= w_a;
            r_alu_b <= w_b;
            r_aluc  <= w_aluc;
            r_dest  <= w_dest;
            r_state <= S_EXEC;
          end else begin
            r_ill   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_EXEC: begin
          r_wd    <= ALU_R;
          r_wa    <= r_dest;
          r_state <= S_WB;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Pulses and status are masked by RST so a reset in WB never writes
  assign INS_READY = (r_state == S_IDLE) && !RST;
  assign BUSY      = (r_state != S_IDLE) && !RST;
  assign RF_WE     = (r_state == S_WB) && (r_wa != '0) && !RST;
  assign ILLEGAL   = r_ill && !RST;
  assign RF_RA1    = r_ra1;
  assign RF_RA2    = r_ra2;
  assign ALU_A     = r_alu_a;
  assign ALU_B     = r_alu_b;
  assign ALUC      = r_aluc;
  assign RF_WA     = r_wa;
  assign RF_WD     = r_wd;

endmodule

// File: tb/tb_alu_issue_controller.sv
// Bench for alu_issue_controller: a register-file array and ALU model sit
// around the DUT; an instruction-level reference model predicts each result.
module tb_alu_issue_controller;

  logic        CLK = 1'b0;
  logic        RST;
  logic        INS_VALID;
  logic        INS_READY;
  logic [31:0] INS;
  logic [4:0]  RF_RA1, RF_RA2, RF_WA;
  logic [31:0] RF_RD1, RF_RD2, ALU_A, ALU_B, ALU_R, RF_WD;
  logic [3:0]  ALUC;
  logic        RF_WE, ILLEGAL, BUSY;

  logic [31:0] rf [32];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cycle = 0;

  alu_issue_controller #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .CLK(CLK), .RST(RST), .INS_VALID(INS_VALID), .INS_READY(INS_READY),
    .INS(INS), .RF_RA1(RF_RA1), .RF_RA2(RF_RA2), .RF_RD1(RF_RD1),
    .RF_RD2(RF_RD2), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALUC(ALUC),
    .ALU_R(ALU_R), .RF_WE(RF_WE), .RF_WA(RF_WA), .RF_WD(RF_WD),
    .ILLEGAL(ILLEGAL), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle <= cycle + 1;

  assign RF_RD1 = rf[RF_RA1];
  assign RF_RD2 = rf[RF_RA2];

  // Combinational ALU responder
  always_comb begin
    ALU_R = '0;
    case (ALUC)
      4'b0000: ALU_R = ALU_A + ALU_B;
      4'b0100: ALU_R = ALU_A - ALU_B;
      4'b0001: ALU_R = ALU_A & ALU_B;
      4'b0101: ALU_R = ALU_A | ALU_B;
      4'b0010: ALU_R = ALU_A ^ ALU_B;
      4'b0110: ALU_R = ALU_B << 16;
      4'b0011: ALU_R = ALU_B << ALU_A[4:0];
      4'b0111: ALU_R = ALU_B >> ALU_A[4:0];
      4'b1111: ALU_R = $signed(ALU_B) >>> ALU_A[4:0];
      default: ALU_R = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] rtype(input int rs, rt, rd, sh, input logic [5:0] fn);
    return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Instruction-level reference: operands, control word and final result
  function automatic void ref_model(input logic [31:0] ins, output bit legal,
      output logic [4:0] dest, output logic [31:0] a, output logic [31:0] b,
      output logic [3:0] aluc, output logic [31:0] res);
    logic [31:0] rs, rt, se, ze, sh;
    rs = rf[ins[25:21]];
    rt = rf[ins[20:16]];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    sh = {27'h0, ins[10:6]};
    legal = 1'b1; a = rs; b = rt; aluc = 4'b0000; res = '0;
    dest = (ins[31:26] == 6'b0) ? ins[15:11] : ins[20:16];
    if (ins[31:26] == 6'b0) begin
      case (ins[5:0])
        6'b100000: begin aluc = 4'b0000; res = rs + rt; end
        6'b100010: begin aluc = 4'b0100; res = rs - rt; end
        6'b100100: begin aluc = 4'b0001; res = rs & rt; end
        6'b100101: begin aluc = 4'b0101; res = rs | rt; end
        6'b100110: begin aluc = 4'b0010; res = rs ^ rt; end
        6'b000000: begin aluc = 4'b0011; a = sh; res = rt << sh; end
        6'b000010: begin aluc = 4'b0111; a = sh; res = rt >> sh; end
        6'b000011: begin aluc = 4'b1111; a = sh; res = $signed(rt) >>> sh; end
        default:   legal = 1'b0;
      endcase
    end else begin
      b = ze;
      case (ins[31:26])
        6'b001000: begin b = se; res = rs + se; end
        6'b001100: begin aluc = 4'b0001; res = rs & ze; end
        6'b001101: begin aluc = 4'b0101; res = rs | ze; end
        6'b001110: begin aluc = 4'b0010; res = rs ^ ze; end
        6'b001111: begin aluc = 4'b0110; a = 0; res = {ins[15:0], 16'h0}; end
        default:   legal = 1'b0;
      endcase
    end
  endfunction

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!INS_READY && n < 20) begin step(); n++; end
    chk("hs_ready", 32'(INS_READY), 32'd1);
  endtask

  // Full issue of one instruction with cycle-by-cycle checks T1..T4
  task automatic run_ins(input logic [31:0] ins);
    bit legal; logic [4:0] dest; logic [31:0] a, b, res; logic [3:0] aluc;
    ref_model(ins, legal, dest, a, b, aluc, res);
    INS = ins; INS_VALID = 1'b1;
    wait_ready();
    step();                                      // T1 DECODE
    INS_VALID = 1'b0; INS = $urandom;
    chk("t1_busy", 32'(BUSY), 32'd1);
    chk("t1_ready", 32'(INS_READY), 32'd0);
    chk("t1_ra1", 32'(RF_RA1), 32'(ins[25:21]));
    chk("t1_ra2", 32'(RF_RA2), 32'(ins[20:16]));
    step();                                      // T2
    if (!legal) begin
      chk("ill_pulse", 32'(ILLEGAL), 32'd1);
      chk("ill_ready", 32'(INS_READY), 32'd1);
      chk("ill_we", 32'(RF_WE), 32'd0);
      return;
    end
    chk("t2_ill", 32'(ILLEGAL), 32'd0);
    chk("t2_aluc", 32'(ALUC), 32'(aluc));
    chk("t2_a", ALU_A, a);
    chk("t2_b", ALU_B, b);
    chk("t2_we", 32'(RF_WE), 32'd0);
    step();                                      // T3 WB
    chk("t3_we", 32'(RF_WE), (dest != 0) ? 32'd1 : 32'd0);
    chk("t3_busy", 32'(BUSY), 32'd1);
    if (dest != 0) begin
      chk("t3_wa", 32'(RF_WA), 32'(dest));
      chk("t3_wd", RF_WD, res);
      rf[dest] = res;
    end
    step();                                      // T4
    chk("t4_ready", 32'(INS_READY), 32'd1);
    chk("t4_we", 32'(RF_WE), 32'd0);
    chk("t4_busy", 32'(BUSY), 32'd0);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [5:0] fns [8];
    logic [5:0] ops [5];
    int k;
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
            6'b000000, 6'b000010, 6'b000011};
    ops = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111};
    k = $urandom_range(0, 19);
    if (k < 8)  return rtype($urandom_range(0, 31), $urandom_range(0, 31),
                             $urandom_range(0, 31), $urandom_range(0, 31), fns[k]);
    if (k < 13) return itype(ops[k-8], $urandom_range(0, 31), $urandom_range(0, 31), 16'($urandom));
    if (k < 15) return itype(6'b111111, 1, 2, 16'($urandom));
    if (k < 16) return rtype(1, 2, 3, 0, 6'b111111);
    return rtype($urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), 0, 6'b100000);
  endfunction

  initial begin
    logic [31:0] prog [3];
    int hs [$];
    int idx;
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : $urandom;

    // Reset held 2 cycles with INS_VALID asserted
    RST = 1'b1; INS_VALID = 1'b1; INS = rtype(1, 2, 3, 0, 6'b100000);
    repeat (2) step();
    chk("rst_ready", 32'(INS_READY), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_we", 32'(RF_WE), 32'd0);
    chk("rst_ill", 32'(ILLEGAL), 32'd0);
    chk("rst_ra", {RF_RA1, RF_RA2, RF_WA}, 32'd0);
    chk("rst_wd", RF_WD, 32'd0);
    chk("rst_a", ALU_A, 32'd0);
    chk("rst_b", ALU_B, 32'd0);
    chk("rst_aluc", 32'(ALUC), 32'd0);
    RST = 1'b0; INS_VALID = 1'b0; #1;
    chk("post_rst_ready", 32'(INS_READY), 32'd1);
    chk("post_rst_busy", 32'(BUSY), 32'd0);

    // Directed cases
    rf[1] = 32'd5; rf[2] = 32'd7;
    run_ins(rtype(1, 2, 3, 0, 6'b100000));                 // add $3,$1,$2
    chk("add_rf3", rf[3], 32'h0000_000C);
    run_ins(itype(6'b001000, 1, 4, 16'hFFFF));             // addi
    run_ins(itype(6'b001101, 1, 5, 16'hFFFF));             // ori
    run_ins(itype(6'b001111, 0, 6, 16'h1234));             // lui
    chk("lui_rf6", rf[6], 32'h1234_0000);
    rf[2] = 32'h8000_0000;
    run_ins(rtype(0, 2, 7, 4, 6'b000011));                 // sra
    chk("sra_rf7", rf[7], 32'hF800_0000);
    run_ins(rtype(9, 2, 8, 31, 6'b000000));                // sll shamt 31
    run_ins(itype(6'b111111, 1, 2, 16'h0));                // illegal opcode
    run_ins(rtype(1, 2, 0, 0, 6'b100000));                 // add rd=0

    // Randomized stream
    for (int i = 0; i < 40; i++) run_ins(rand_ins());

    // Back-to-back with INS_VALID held high
    prog[0] = rtype(1, 2, 10, 0, 6'b100000);
    prog[1] = itype(6'b001110, 10, 11, 16'h5A5A);
    prog[2] = rtype(11, 10, 12, 0, 6'b100010);
    idx = 0; INS = prog[0]; INS_VALID = 1'b1;
    for (int c = 0; c < 40 && idx < 3; c++) begin
      if (INS_READY) begin
        hs.push_back(cycle); idx++;
        step();
        if (idx < 3) INS = prog[idx]; else INS_VALID = 1'b0;
      end else step();
    end
    chk("b2b_count", 32'(hs.size()), 32'd3);
    if (hs.size() == 3) begin
      chk("b2b_gap1", 32'(hs[1] - hs[0]), 32'd4);
      chk("b2b_gap2", 32'(hs[2] - hs[1]), 32'd4);
    end
    repeat (4) step();
    begin
      bit l; logic [4:0] d; logic [31:0] a, b, r; logic [3:0] u;
      for (int i = 0; i < 3; i++) begin ref_model(prog[i], l, d, a, b, u, r); rf[d] = r; end
    end

    // Reset during EXEC aborts the write
    INS = itype(6'b001101, 1, 13, 16'h00FF); INS_VALID = 1'b1;
    wait_ready();
    step(); INS_VALID = 1'b0;                    // DECODE
    step(); RST = 1'b1;                          // EXEC with reset
    step(); RST = 1'b0;
    chk("rst_exec_we", 32'(RF_WE), 32'd0);
    chk("rst_exec_busy", 32'(BUSY), 32'd0);
    step();
    chk("rst_exec_we2", 32'(RF_WE), 32'd0);
    chk("rst_exec_ready", 32'(INS_READY), 32'd1);
    run_ins(rtype(1, 2, 14, 0, 6'b100101));      // accepted after reset

    // Reset coinciding with WB suppresses RF_WE
    INS = rtype(1, 2, 15, 0, 6'b100000); INS_VALID = 1'b1;
    wait_ready();
    step(); INS_VALID = 1'b0;
    step();
    step(); RST = 1'b1; #1;
    chk("rst_wb_we", 32'(RF_WE), 32'd0);
    step(); RST = 1'b0;
    chk("rst_wb_busy", 32'(BUSY), 32'd0);
    run_ins(itype(6'b001100, 2, 16, 16'hF0F0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
